// File: rtl/alu_mul_seq.sv
// Purpose: sequences the shared ALU through shift-and-add to form the low WIDTH bits of a*b.
// Latency: done pulses 1+WIDTH+popcount(b) cycles after the accepted start (9..17 for WIDTH=8).
// Backpressure: none; start is only sampled in IDLE, and start while busy is dropped.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, a, b          request and operands (latched when start is accepted)
//   busy, done           busy = not idle; done = one-cycle result-valid pulse
//   result, zero, ovf    registered low product bits, ALU zero of last op, sticky overflow
//   alu_a, alu_b, alu_op ALU drive (combinational from state)
//   alu_y, alu_zero      ALU combinational result and zero flag
module alu_mul_seq #(
    parameter int         WIDTH   = 8,
    parameter logic [2:0] OP_PASS = 3'b000,
    parameter logic [2:0] OP_ADD  = 3'b010,
    parameter logic [2:0] OP_SHL  = 3'b111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_ADD   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic             ovf_q;

    // ALU operands follow the state directly so the ALU result is ready
    // within the same cycle the state needs it.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_PASS;
        case (state_q)
            S_SHIFT: begin
                alu_a  = acc_q;
                alu_op = OP_SHL;
            end
            S_ADD: begin
                alu_a  = acc_q;
                alu_b  = mcand_q;
                alu_op = OP_ADD;
            end
            default: ;
        endcase
    end

    // MSB-first: each multiplier bit costs one shift, plus one add when set.
    // The add for a bit stays on the same cnt; cnt steps only when leaving the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q    <= '0;
                        mcand_q  <= a;
                        mplier_q <= b;
                        cnt_q    <= CW'(WIDTH - 1);
                        ovf_q    <= 1'b0;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_q <= alu_y;
                    // A set MSB is about to be shifted out of the accumulator.
                    ovf_q <= ovf_q | acc_q[WIDTH-1];
                    if (mplier_q[cnt_q]) begin
                        state_q <= S_ADD;
                    end else if (cnt_q == '0) begin
                        result_q <= alu_y;
                        zero_q   <= alu_zero;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_ADD: begin
                    acc_q <= alu_y;
                    // Unsigned wrap on the add means a carry out of WIDTH bits.
                    ovf_q <= ovf_q | (alu_y < acc_q);
                    if (cnt_q == '0) begin
                        result_q <= alu_y;
                        zero_q   <= alu_zero;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q - CW'(1);
                        state_q <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Purpose: directed bench for alu_mul_seq with a behavioural model of the shared ALU.
// Latency: each operation is followed cycle by cycle until done or a cycle budget expires.
// Backpressure: n/a; inputs change on the falling edge, outputs are sampled on the falling edge.
module tb_alu_mul_seq;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SHL  = 3'b111;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       zero;
    logic       ovf;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_y;
    logic       alu_zero;

    int errors = 0;
    int checks = 0;

    alu_mul_seq #(
        .WIDTH  (8),
        .OP_PASS(OP_PASS),
        .OP_ADD (OP_ADD),
        .OP_SHL (OP_SHL)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .zero    (zero),
        .ovf     (ovf),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_y   (alu_y),
        .alu_zero(alu_zero)
    );

    // Shared ALU model: pass, add, shift-left-by-1.
    always_comb begin
        alu_y = 8'h00;
        case (alu_op)
            OP_PASS: alu_y = alu_a;
            OP_ADD:  alu_y = alu_a + alu_b;
            OP_SHL:  alu_y = {alu_a[6:0], 1'b0};
            default: alu_y = 8'h00;
        endcase
        alu_zero = (alu_y == 8'h00);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launches a*b during the current cycle, then follows it to done.
    // Expected op sequence: per multiplier bit (MSB first) one SHL, then ADD if set.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input int exp_lat, input logic [7:0] exp_res,
                          input logic exp_zero, input logic exp_ovf);
        logic [2:0] ops[$];
        int         done_at;
        ops.delete();
        for (int i = 7; i >= 0; i--) begin
            ops.push_back(OP_SHL);
            if (tb_v[i]) ops.push_back(OP_ADD);
        end
        a       = ta;
        b       = tb_v;
        start   = 1'b1;
        done_at = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (done === 1'b1) begin
                done_at = n;
                break;
            end
            chk({tag, "_busy"}, busy, 1'b1);
            if (n <= ops.size()) chk({tag, "_op"}, alu_op, ops[n-1]);
        end
        chk({tag, "_latency"}, done_at, exp_lat);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_zero"}, zero, exp_zero);
        chk({tag, "_ovf"}, ovf, exp_ovf);
        chk({tag, "_done_busy"}, busy, 1'b1);
        chk({tag, "_done_op"}, alu_op, OP_PASS);
        @(negedge clk);
        chk({tag, "_post_done"}, done, 1'b0);
        chk({tag, "_post_busy"}, busy, 1'b0);
        chk({tag, "_hold_result"}, result, exp_res);
    endtask

    int dcount;
    int dat;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 8'h00);
        chk("rst_zero", zero, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_alu_op", alu_op, OP_PASS);
        chk("rst_alu_a", alu_a, 8'h00);
        reset = 1'b0;

        // 5*3 = 15, two set bits -> 11 cycles.
        run_op("m5x3", 8'h05, 8'h03, 11, 8'h0F, 1'b0, 1'b0);
        // b=0: only shifts -> 9 cycles, zero result.
        run_op("mFFx00", 8'hFF, 8'h00, 9, 8'h00, 1'b1, 1'b0);
        // 0x10*0x10 = 0x100: low byte 0, the final shift of 0x80 overflows.
        run_op("m10x10", 8'h10, 8'h10, 10, 8'h00, 1'b1, 1'b1);
        // 0xFF*0xFF = 0xFE01 -> 17 cycles.
        run_op("mFFxFF", 8'hFF, 8'hFF, 17, 8'h01, 1'b0, 1'b1);

        // Starts during SHIFT, ADD and DONE are dropped; operand changes ignored.
        a      = 8'h05;
        b      = 8'h03;
        start  = 1'b1;
        dcount = 0;
        dat    = -1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) begin
                dcount++;
                dat = n;
            end
            if (n == 3 || n == 10 || n == 11) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'hFF;
            end
        end
        chk("ign_done_count", dcount, 1);
        chk("ign_done_cycle", dat, 11);
        chk("ign_result", result, 8'h0F);
        chk("ign_idle_c12", busy, 1'b0);
        // Start during cycle 12 (idle) is accepted: 2*3 = 6.
        run_op("m2x3", 8'h02, 8'h03, 11, 8'h06, 1'b0, 1'b0);

        // Reset at cycle 4 aborts; outputs cleared, no done pulse.
        a     = 8'h05;
        b     = 8'h03;
        start = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 4) reset = 1'b1;
        end
        chk("abort_busy_before", busy, 1'b1);
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 8'h00);
        chk("abort_alu_op", alu_op, OP_PASS);
        chk("abort_ovf", ovf, 1'b0);
        reset  = 1'b0;
        dcount = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        chk("abort_quiet", dcount, 0);

        // Normal operation after abort: 7*9 = 63.
        run_op("m7x9", 8'h07, 8'h09, 11, 8'h3F, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
